program_loader: RTL
===================

# program_loader

Byte-stream loader that fills the Hack instruction ROM with 16-bit instructions, the writer side of the path whose reader is the CPU's instruction decode. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian instruction words, and writes them to consecutive ROM addresses from 0. It holds the CPU in reset for the whole load and validates the frame with an XOR checksum. It sits between the host link (UART/debug bridge) and the ROM write port.

## Interface
- ADDR_W, 15, ROM address width; capacity 2^ADDR_W words.
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
- abort_i  in  1  level; forces ERROR while a load is in progress
- byte_i  in  8  stream byte
- byte_valid_i  in  1  byte_i valid
- byte_ready_o  out  1  loader accepts byte; transfer when valid & ready
- rom_we_o  out  1  one-cycle ROM write strobe
- rom_addr_o  out  ADDR_W  ROM write address
- rom_data_o  out  16  ROM write data
- cpu_hold_o  out  1  CPU reset request, high during load and in ERROR
- done_o  out  1  load completed, checksum good
- error_o  out  1  load failed

## Operation
- Frame: LEN_HI, LEN_LO (word count N, 16-bit big-endian), then N words as HI byte then LO byte, then one CHK byte = XOR of every preceding frame byte, length bytes included.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start_i -> LEN_HI. Clears the word address, checksum accumulator, done_o and error_o. Sets cpu_hold_o.
- LEN_HI -> LEN_LO on a byte transfer.
- LEN_LO on a byte transfer:
  - N > 2^ADDR_W -> ERROR.
  - N == 0 -> CHECK.
  - Otherwise -> DATA_HI.
- DATA_HI -> DATA_LO on a byte transfer; the byte is latched as the high half.
- DATA_LO on a byte transfer:
  - Registers {hi, byte} to rom_data_o and the current address to rom_addr_o.
  - Increments the address and decrements the remaining count.
  - Goes to CHECK when the count reaches 0, otherwise to DATA_HI.
- CHECK on a byte transfer: byte == accumulator -> DONE, otherwise -> ERROR.
- Accumulator XORs in every transferred byte in LEN_HI..DATA_LO.
- DONE: cpu_hold_o=0, done_o=1. ERROR: cpu_hold_o=1, error_o=1. Both persist until start_i or reset.
- start_i while in LEN_HI..CHECK is ignored.
- abort_i in LEN_HI..CHECK -> ERROR next cycle. It has priority over a simultaneous byte transfer, and that byte is dropped.
- Address arithmetic is ADDR_W bits. N == 2^ADDR_W is legal: the last write goes to address 2^ADDR_W-1 and the address wraps to 0 unused.

## Timing
- Reset values: state IDLE, byte_ready_o=0, rom_we_o=0, rom_addr_o=0, rom_data_o=0, cpu_hold_o=0, done_o=0, error_o=0.
- All outputs are registered or decoded from state only; there is no combinational path from byte_valid_i to byte_ready_o.
- byte_ready_o=1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK, including the cycle in which rom_we_o is high.
- start_i at edge k -> cpu_hold_o=1 and byte_ready_o=1 from cycle k+1.
- DATA_LO transfer at edge k -> rom_we_o=1 with stable addr/data for cycle k+1 only. rom_addr_o/rom_data_o hold their values until the next write.
- CHECK transfer at edge k -> done_o or error_o high from cycle k+1. cpu_hold_o drops at k+1 on success.
- Idle gaps (byte_valid_i=0) of any length are allowed in every receiving state; the state does not advance.
- Minimum full-rate load of N words takes 2N+3 transfer cycles.
- Asynchronous reset mid-load returns to IDLE immediately: cpu_hold_o=0, no further writes. Partially written ROM contents are not erased.

## Test plan
- Nominal load: start, then bytes 00 03 00 10 EC 10 00 03 EC at full rate.
  - Required: writes (0,0x0010), (1,0xEC10), (2,0x0003), each a single rom_we_o pulse.
  - done_o=1 and cpu_hold_o=0 one cycle after the EC checksum byte.
- Bad checksum: same frame, checksum byte ED.
  - Required: three writes, then error_o=1, cpu_hold_o=1, done_o=0, byte_ready_o=0.
- Zero length: 00 00 00.
  - Required: no writes, done_o=1.
  - Separately, 00 00 01 -> error_o=1.
- Overflow with ADDR_W=2: length 00 05.
  - Required: error_o=1 right after LEN_LO, no writes.
  - Separately, length 00 04 with a valid checksum writes addresses 0..3 and reaches done_o=1.
- Backpressure/gaps and ignored controls:
  - Random byte_valid_i gaps on the nominal frame -> same writes and result.
  - start_i pulse mid-frame -> ignored.
  - abort_i coincident with a DATA_LO byte -> no write, error_o=1.
- Reset mid-load: assert rst_i after the second data word.
  - Required: all outputs at reset values immediately, with no rom_we_o after reset.
  - A subsequent full nominal load completes with done_o=1.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
//   Fills the Hack instruction ROM from a framed byte stream. The frame is
//   LEN_HI, LEN_LO (big-endian word count N), N big-endian words, then one
//   XOR checksum byte covering every byte before it. The CPU is held in reset
//   for the whole load and for the whole time the loader is in ERROR.
//
// Ports
//   clk_i, rst_i         clock, async active-high reset
//   start_i              one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   abort_i              level, forces ERROR while a load is in progress
//   byte_i/byte_valid_i  stream in; byte_ready_o is decoded from state only
//   rom_we_o/addr/data   registered ROM write port, one-cycle strobe
//   cpu_hold_o           CPU reset request
//   done_o / error_o     sticky result until the next start or reset
module program_loader #(
  parameter int ADDR_W = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [15:0]       rom_data_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  // Largest legal word count: the full ROM.
  localparam logic [31:0] CAP = 32'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       cnt_q;
  logic [7:0]        hi_q;   // LEN_HI byte, then each word's high byte
  logic [7:0]        acc_q;

  logic        loading, xfer, idle_like;
  logic [15:0] n_word;

  assign loading   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                     (state_q == S_CHECK);
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) ||
                     (state_q == S_ERROR);
  // A byte is consumed only when no abort is pending; abort drops it.
  assign xfer      = loading && byte_valid_i && !abort_i;
  assign n_word    = {hi_q, byte_i};

  assign byte_ready_o = loading;
  assign cpu_hold_o   = loading || (state_q == S_ERROR);
  assign done_o       = (state_q == S_DONE);
  assign error_o      = (state_q == S_ERROR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (idle_like) begin
      if (start_i) state_d = S_LEN_HI;
    end else if (abort_i) begin
      state_d = S_ERROR;
    end else if (xfer) begin
      case (state_q)
        S_LEN_HI:  state_d = S_LEN_LO;
        S_LEN_LO: begin
          if ({16'd0, n_word} > CAP) state_d = S_ERROR;
          else if (n_word == 16'd0)  state_d = S_CHECK;
          else                       state_d = S_DATA_HI;
        end
        S_DATA_HI: state_d = S_DATA_LO;
        S_DATA_LO: state_d = (cnt_q == 16'd1) ? S_CHECK : S_DATA_HI;
        S_CHECK:   state_d = (byte_i == acc_q) ? S_DONE : S_ERROR;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      acc_q      <= '0;
      rom_we_o   <= 1'b0;
      rom_addr_o <= '0;
      rom_data_o <= '0;
    end else begin
      rom_we_o <= 1'b0;
      if (idle_like && start_i) begin
        addr_q <= '0;
        acc_q  <= '0;
      end else if (xfer) begin
        case (state_q)
          S_LEN_HI: begin
            hi_q  <= byte_i;
            acc_q <= acc_q ^ byte_i;
          end
          S_LEN_LO: begin
            cnt_q <= n_word;
            acc_q <= acc_q ^ byte_i;
          end
          S_DATA_HI: begin
            hi_q  <= byte_i;
            acc_q <= acc_q ^ byte_i;
          end
          S_DATA_LO: begin
            rom_we_o   <= 1'b1;
            rom_addr_o <= addr_q;
            rom_data_o <= n_word;
            // Wraps to 0 after a full-ROM load; that address is never used.
            addr_q     <= addr_q + ADDR_W'(1);
            cnt_q      <= cnt_q - 16'd1;
            acc_q      <= acc_q ^ byte_i;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
